// File: rtl/fft_ctrl_pkg.sv
// Shared types and defaults for the FFT frame sequencer.
package fft_ctrl_pkg;
  localparam int N_POINTS_DEF = 512;
  localparam int ADDR_W_DEF   = 9;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    CLEAR      = 3'd1,
    FILL       = 3'd2,
    WAIT_DRAIN = 3'd3,
    LOAD       = 3'd4,
    START      = 3'd5,
    RUN        = 3'd6
  } fft_state_e;
endpackage

// File: rtl/fft_watchdog.sv
// RUN-phase watchdog: cleared on START, counts while running, flags TERM-1.
module fft_watchdog #(
  parameter int TO_W = 16,
  parameter int TERM = 65535
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);
  logic [TO_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)       cnt_d = '0;
    else if (enable_i) cnt_d = cnt_q + TO_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expired_o = (cnt_q == TO_W'(TERM - 1));
endmodule

// File: rtl/fft_frame_sequencer.sv
// Frame controller: clear -> fill -> wait drain -> load into FFT -> start -> run.
module fft_frame_sequencer
  import fft_ctrl_pkg::*;
#(
  parameter int N_POINTS    = N_POINTS_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int RUN_TIMEOUT = 65535,
  parameter int TO_W        = 16,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              sample_valid,
  input  logic              in_buffer_full,
  output logic              clear_frame,
  output logic [ADDR_W-1:0] fft_read_addr,
  output logic              load_valid,
  output logic [ADDR_W-1:0] load_addr,
  output logic              load_last,
  input  logic              out_buffer_ready,
  output logic              fft_start,
  input  logic              fft_done,
  output logic              busy,
  output logic [2:0]        state_o,
  output logic [CNT_W-1:0]  frame_count,
  output logic              overrun,
  output logic              timeout_err,
  input  logic              err_clear
);
  localparam int              LC_W    = ADDR_W + 1;
  localparam logic [LC_W-1:0] LC_LAST = LC_W'(N_POINTS);

  fft_state_e        state_q, state_d;
  logic [LC_W-1:0]   ld_cnt_q, ld_cnt_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d, ld_addr_q, ld_addr_d;
  logic              ld_valid_q, ld_valid_d, ld_last_q, ld_last_d;
  logic              clear_q, start_q, busy_q;
  logic [CNT_W-1:0]  fc_q, fc_d;
  logic              ovr_q, ovr_d, to_q, to_d;
  logic              wd_expired, frame_done, frame_to, ovr_set;

  fft_watchdog #(.TO_W(TO_W), .TERM(RUN_TIMEOUT)) u_wd (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (state_d == START),
    .enable_i  (state_d == RUN),
    .expired_o (wd_expired)
  );

  always_comb begin
    state_d    = state_q;
    frame_done = 1'b0;
    frame_to   = 1'b0;
    case (state_q)
      IDLE:       if (enable) state_d = CLEAR;
      CLEAR:      state_d = FILL;
      FILL:       if (in_buffer_full) state_d = WAIT_DRAIN;
      WAIT_DRAIN: if (!out_buffer_ready) state_d = LOAD;
      LOAD:       if (ld_cnt_q == LC_LAST) state_d = START;
      START:      state_d = RUN;
      RUN: begin
        // done beats a same-cycle watchdog expiry
        frame_done = fft_done;
        frame_to   = wd_expired && !fft_done;
        if (frame_done || frame_to) state_d = enable ? CLEAR : IDLE;
      end
      default:    state_d = IDLE;
    endcase
  end

  // Load cycle k reads address k; data returns a cycle later as load_addr k.
  always_comb begin
    ld_cnt_d   = (state_q == LOAD && state_d == LOAD) ? ld_cnt_q + LC_W'(1) : '0;
    ld_valid_d = (state_d == LOAD) && (ld_cnt_d != '0);
    ld_last_d  = (state_d == LOAD) && (ld_cnt_d == LC_LAST);
    rd_addr_d  = (state_d == LOAD && ld_cnt_d != LC_LAST) ? ADDR_W'(ld_cnt_d) : '0;
    ld_addr_d  = ld_valid_d ? ADDR_W'(ld_cnt_d - LC_W'(1)) : '0;
    fc_d       = frame_done ? fc_q + CNT_W'(1) : fc_q;
    ovr_set    = sample_valid && (!(state_q == IDLE || state_q == FILL) ||
                                  (state_q == FILL && in_buffer_full));
    ovr_d      = ovr_set  | (ovr_q & ~err_clear);
    to_d       = frame_to | (to_q  & ~err_clear);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      ld_cnt_q   <= '0;
      rd_addr_q  <= '0;
      ld_addr_q  <= '0;
      ld_valid_q <= 1'b0;
      ld_last_q  <= 1'b0;
      clear_q    <= 1'b0;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
      fc_q       <= '0;
      ovr_q      <= 1'b0;
      to_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      ld_cnt_q   <= ld_cnt_d;
      rd_addr_q  <= rd_addr_d;
      ld_addr_q  <= ld_addr_d;
      ld_valid_q <= ld_valid_d;
      ld_last_q  <= ld_last_d;
      clear_q    <= (state_d == CLEAR);
      start_q    <= (state_d == START);
      busy_q     <= (state_d != IDLE);
      fc_q       <= fc_d;
      ovr_q      <= ovr_d;
      to_q       <= to_d;
    end
  end

  assign clear_frame   = clear_q;
  assign fft_read_addr = rd_addr_q;
  assign load_valid    = ld_valid_q;
  assign load_addr     = ld_addr_q;
  assign load_last     = ld_last_q;
  assign fft_start     = start_q;
  assign busy          = busy_q;
  assign state_o       = state_q;
  assign frame_count   = fc_q;
  assign overrun       = ovr_q;
  assign timeout_err   = to_q;
endmodule
